// File: rtl/seq_divmod_pkg.sv
// seq_divmod_pkg: shared state encoding and divide-by-zero quotient fill for seq_divmod.
package seq_divmod_pkg;
   typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;
   // A zero divisor yields a quotient with every bit set to this value.
   localparam logic DBZ_QUO_BIT = 1'b1;
endpackage

// File: rtl/divmod_cneg.sv
// divmod_cneg: conditional two's-complement negate of a W-bit value.
module divmod_cneg import seq_divmod_pkg::*; #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic         neg,
   output logic [W-1:0] y
);
   assign y = neg ? W'(0) - a : a;
endmodule

// File: rtl/seq_divmod.sv
// seq_divmod: sequential restoring divider, one quotient bit per cycle, valid/ready in and out.
// Define SEQ_DIVMOD_SIGNED_EN to honour is_signed and add the one-cycle FIX sign-correction state.
module seq_divmod import seq_divmod_pkg::*; #(
   parameter int NUM_W = 8,
   parameter int DEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   input  logic             is_signed,
   input  logic             nd_valid,
   output logic             nd_ready,
   output logic             qr_valid,
   input  logic             qr_ready,
   output logic [NUM_W-1:0] quo,
   output logic [DEN_W-1:0] rem,
   output logic             div_by_zero,
   output logic             busy
);
   localparam int CW = $clog2(NUM_W);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [NUM_W-1:0] dvd, dvd_n, num_mag;
   logic [DEN_W-1:0] dsr, den_mag;
   logic [DEN_W:0] r, r_n;
   logic [DEN_W+1:0] sh, diff;
   logic acc, last, sgn;

   assign acc  = nd_valid && nd_ready;
   assign last = cnt == CW'(NUM_W - 1);

`ifdef SEQ_DIVMOD_SIGNED_EN
   logic neg_q, neg_r;
   logic [NUM_W-1:0] q_fix;
   logic [DEN_W-1:0] r_fix;
   assign sgn = is_signed;
   divmod_cneg #(.W(NUM_W)) u_qfix (.a(dvd), .neg(neg_q), .y(q_fix));
   divmod_cneg #(.W(DEN_W)) u_rfix (.a(r[DEN_W-1:0]), .neg(neg_r), .y(r_fix));
`else
   logic unused_sgn;
   assign sgn        = 1'b0;
   assign unused_sgn = is_signed;
`endif

   divmod_cneg #(.W(NUM_W)) u_nmag (.a(num), .neg(sgn && num[NUM_W-1]), .y(num_mag));
   divmod_cneg #(.W(DEN_W)) u_dmag (.a(den), .neg(sgn && den[DEN_W-1]), .y(den_mag));

   // Trial subtraction is one bit wider than the shifted remainder so its sign is the borrow.
   assign sh    = {r, dvd[NUM_W-1]};
   assign diff  = sh - {2'b0, dsr};
   assign r_n   = diff[DEN_W+1] ? sh[DEN_W:0] : diff[DEN_W:0];
   assign dvd_n = {dvd[NUM_W-2:0], ~diff[DEN_W+1]};

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = acc ? ((den == '0) ? DONE : DIV) : IDLE;
`ifdef SEQ_DIVMOD_SIGNED_EN
         DIV:  state_n = last ? FIX : DIV;
`else
         DIV:  state_n = last ? DONE : DIV;
`endif
         FIX:  state_n = DONE;
         DONE: state_n = qr_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      nd_ready = state == IDLE;
      qr_valid = state == DONE;
      busy     = state != IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         dvd         <= '0;
         dsr         <= '0;
         r           <= '0;
         quo         <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_DIVMOD_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (acc) begin
               cnt <= '0;
               dvd <= num_mag;
               dsr <= den_mag;
               r   <= '0;
`ifdef SEQ_DIVMOD_SIGNED_EN
               neg_q <= sgn && (num[NUM_W-1] ^ den[DEN_W-1]);
               neg_r <= sgn && num[NUM_W-1];
`endif
               if (den == '0) begin
                  quo         <= {NUM_W{DBZ_QUO_BIT}};
                  rem         <= num[DEN_W-1:0];
                  div_by_zero <= 1'b1;
               end
            end
            DIV: begin
               cnt <= last ? '0 : cnt + 1'b1;
               dvd <= dvd_n;
               r   <= r_n;
`ifndef SEQ_DIVMOD_SIGNED_EN
               if (last) begin
                  quo         <= dvd_n;
                  rem         <= r_n[DEN_W-1:0];
                  div_by_zero <= 1'b0;
               end
`endif
            end
`ifdef SEQ_DIVMOD_SIGNED_EN
            FIX: begin
               quo         <= q_fix;
               rem         <= r_fix;
               div_by_zero <= 1'b0;
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divmod.sv
// tb_seq_divmod: directed self-checking bench for seq_divmod (NUM_W=DEN_W=8), either build.
module tb_seq_divmod;
   logic clk = 1'b0;
   logic rst, is_signed, nd_valid, nd_ready, qr_valid, qr_ready, div_by_zero, busy;
   logic [7:0] num, den, quo, rem;
   int n_chk = 0;
   int n_fail = 0;
`ifdef SEQ_DIVMOD_SIGNED_EN
   localparam int LAT = 10;
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam int LAT = 9;
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   seq_divmod #(.NUM_W(8), .DEN_W(8)) dut (
      .clk(clk), .rst(rst), .num(num), .den(den), .is_signed(is_signed),
      .nd_valid(nd_valid), .nd_ready(nd_ready), .qr_valid(qr_valid), .qr_ready(qr_ready),
      .quo(quo), .rem(rem), .div_by_zero(div_by_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer operands, scramble them after acceptance, and measure cycles until qr_valid.
   task automatic run(input logic [7:0] n, input logic [7:0] d, input logic s, input int exp_lat);
      int lat;
      num = n; den = d; is_signed = s; nd_valid = 1'b1;
      @(posedge clk); #1;
      nd_valid = 1'b0; num = ~n; den = ~d; is_signed = ~s;
      lat = 1;
      while (!qr_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
   endtask

   task automatic result(input string tag, input logic [7:0] q, input logic [7:0] r, input logic z);
      chk({tag, ".quo"}, 32'(quo), 32'(q));
      chk({tag, ".rem"}, 32'(rem), 32'(r));
      chk({tag, ".dbz"}, 32'(div_by_zero), 32'(z));
   endtask

   task automatic handshake(input logic [7:0] q);
      @(posedge clk); #1;
      chk("hs.nd_ready", 32'(nd_ready), 32'd1);
      chk("hs.qr_valid", 32'(qr_valid), 32'd0);
      chk("hs.quo_kept", 32'(quo), 32'(q));
   endtask

   typedef struct {
      logic [7:0] n, d;
      logic s;
      logic [7:0] qs, rs, qu, ru;
   } vec_t;

   vec_t vecs[7] = '{
      '{8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 8'h7C, 8'h01},
      '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 8'h00, 8'h80},
      '{8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 8'h00, 8'h07},
      '{8'hF9, 8'hFE, 1'b1, 8'h03, 8'hFF, 8'h00, 8'hF9},
      '{8'hF9, 8'h02, 1'b0, 8'h7C, 8'h01, 8'h7C, 8'h01},
      '{8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00},
      '{8'h0D, 8'hFF, 1'b0, 8'h00, 8'h0D, 8'h00, 8'h0D}
   };

   initial begin
      logic seen;
      rst = 1'b1; num = '0; den = '0; is_signed = 1'b0; nd_valid = 1'b0; qr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst.nd_ready", 32'(nd_ready), 32'd1);
      chk("rst.qr_valid", 32'(qr_valid), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      result("rst", 8'h00, 8'h00, 1'b0);

      run(8'd200, 8'd7, 1'b0, LAT);
      chk("u200_7.nd_ready", 32'(nd_ready), 32'd0);
      result("u200_7", 8'd28, 8'd4, 1'b0);
      handshake(8'd28);

      run(8'h5A, 8'h00, 1'b1, 1);
      result("dbz", 8'hFF, 8'h5A, 1'b1);
      handshake(8'hFF);

      foreach (vecs[i]) begin
         run(vecs[i].n, vecs[i].d, vecs[i].s, LAT);
         if (SIGNED_BUILD) result($sformatf("vec%0d", i), vecs[i].qs, vecs[i].rs, 1'b0);
         else result($sformatf("vec%0d", i), vecs[i].qu, vecs[i].ru, 1'b0);
         handshake(SIGNED_BUILD ? vecs[i].qs : vecs[i].qu);
      end

      qr_ready = 1'b0;
      run(8'd100, 8'd7, 1'b0, LAT);
      for (int k = 0; k < 5; k++) begin
         num = 8'd9; den = 8'd3; nd_valid = 1'b1;
         @(posedge clk); #1;
         nd_valid = 1'b0;
         chk("hold.qr_valid", 32'(qr_valid), 32'd1);
         chk("hold.nd_ready", 32'(nd_ready), 32'd0);
         result("hold", 8'd14, 8'd2, 1'b0);
      end
      qr_ready = 1'b1;
      handshake(8'd14);

      num = 8'd200; den = 8'd7; is_signed = 1'b0; nd_valid = 1'b1;
      @(posedge clk); #1;
      nd_valid = 1'b0;
      chk("abort.busy", 32'(busy), 32'd1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort.nd_ready", 32'(nd_ready), 32'd1);
      chk("abort.qr_valid", 32'(qr_valid), 32'd0);
      result("abort", 8'h00, 8'h00, 1'b0);
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         seen |= qr_valid;
      end
      chk("abort.no_valid", 32'(seen), 32'd0);
      run(8'd9, 8'd3, 1'b0, LAT);
      result("u9_3", 8'd3, 8'd0, 1'b0);
      handshake(8'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_divmod.md
SEQ_DIVMOD -- requirements
Module: seq_divmod

Interface
REQ-001 SHALL have parameter NUM_W, default 8: dividend and quotient width, >=2.
REQ-002 SHALL have parameter DEN_W, default 8: divisor and remainder width, >=2, <=NUM_W.
REQ-003 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-004 Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- num  in  NUM_W  dividend.
- den  in  DEN_W  divisor.
- is_signed  in  1  two's-complement operation select, sampled with operands.
- nd_valid  in  1  operands valid.
- nd_ready  out  1  block can accept operands.
- qr_valid  out  1  result valid.
- qr_ready  in  1  consumer accepts result.
- quo  out  NUM_W  quotient.
- rem  out  DEN_W  remainder.
- div_by_zero  out  1  result came from den==0, valid with qr_valid.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement four states: IDLE, DIV, FIX, DONE. nd_ready=1 only in IDLE; qr_valid=1 only in DONE.
REQ-006 SHALL accept on a rising edge with nd_valid&&nd_ready and register num, den and is_signed; operand changes after acceptance SHALL be ignored.
REQ-007 SHALL go from IDLE on acceptance to DIV when den!=0, or directly to DONE when den==0.
REQ-008 DIV SHALL run restoring division, one quotient bit per cycle, MSB first, on operand magnitudes, for exactly NUM_W cycles counted by a counter, then go to FIX.
REQ-009 FIX SHALL last one cycle: it negates quo if operand signs differ, and negates rem if the dividend is negative (signed only); it then goes to DONE.
REQ-010 SHALL raise qr_valid exactly NUM_W+2 cycles after the accepting edge for den!=0, and 1 cycle after it for den==0.
REQ-011 Unsigned result SHALL be quo=num/den and rem=num%den.
REQ-012 Signed result SHALL truncate toward zero, with rem carrying the sign of num.
REQ-013 Signed most-negative/-1 SHALL give quo=most-negative (wrap) and rem=0, with no flag.
REQ-014 den==0 SHALL give quo=all ones, rem=num[DEN_W-1:0] and div_by_zero=1, independent of is_signed.
REQ-015 DONE SHALL hold quo, rem and div_by_zero stable until qr_valid&&qr_ready. The block SHALL then go to IDLE on the next edge; no accept SHALL occur in that same cycle.
REQ-016 quo, rem and div_by_zero SHALL keep their last value after the handshake until the next result is loaded.
REQ-017 Internal remainder width SHALL be DEN_W+1 bits so the trial subtraction sign is available; magnitude path SHALL be NUM_W bits unsigned, so |most-negative| fits.

Reset
REQ-018 On rst=1 at a rising edge, in any state including mid-DIV, the block SHALL enter IDLE and abort the operation.
REQ-019 Reset values SHALL be: nd_ready=1, qr_valid=0, quo=0, rem=0, div_by_zero=0, busy=0, counter=0.
REQ-020 An aborted operation SHALL never produce qr_valid.

Configuration
REQ-021 With macro SEQ_DIVMOD_SIGNED_EN defined, is_signed SHALL be honoured and FIX SHALL exist; latency SHALL be per REQ-010.
REQ-022 Without SEQ_DIVMOD_SIGNED_EN, is_signed SHALL be ignored (unsigned only) and FIX SHALL be omitted: DIV goes straight to DONE and latency is NUM_W+1 cycles.

Structure
REQ-023 Package seq_divmod_pkg SHALL hold the state enum typedef (IDLE, DIV, FIX, DONE) and the div-by-zero quotient constant rule.
REQ-024 One sub-module, divmod_cneg (parametrised-width conditional two's-complement negate), SHALL be instantiated for operand magnitude at load and sign fix in FIX.

Verification (NUM_W=DEN_W=8, SEQ_DIVMOD_SIGNED_EN defined unless noted)
REQ-025 Unsigned 200/7, qr_ready=1 -> quo=28, rem=4, div_by_zero=0; qr_valid 10 cycles after accept, nd_ready back 1 cycle after handshake.
REQ-026 num=0x5A, den=0 -> quo=0xFF, rem=0x5A, div_by_zero=1; qr_valid 1 cycle after accept.
REQ-027 Signed -7/2 -> quo=0xFD, rem=0xFF; signed -128/-1 -> quo=0x80, rem=0x00; unsigned 0xF9/2 -> quo=0x7C, rem=1.
REQ-028 qr_ready low 5 cycles in DONE -> quo/rem/qr_valid stable, nd_ready=0, nd_valid pulses ignored; qr_ready high -> IDLE next cycle.
REQ-029 rst pulsed on 4th DIV cycle -> next cycle nd_ready=1, qr_valid=0, quo=rem=0; follow-up 9/3 -> quo=3, rem=0.
REQ-030 Build without SEQ_DIVMOD_SIGNED_EN: is_signed=1, num=0xF9 (249), den=2 -> quo=0x7C, rem=1; qr_valid 9 cycles after accept.
